// File: rtl/hd44780_seq.sv
// hd44780_seq: plays a command list from the hd44780_ram read port onto an
// HD44780 in 4-bit write-only mode. Word ops: 00 byte, 01 delay, 11 stop,
// 10 reserved (skipped).
module hd44780_seq #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned E_CYC      = 12,
    parameter int unsigned HOLD_CYC   = 12,
    parameter int unsigned POST_CYC   = 2000,
    parameter int unsigned TICK_CYC   = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    input  logic [15:0]           i_rdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_lcd_rs,
    output logic                  o_lcd_e,
    output logic [3:0]            o_lcd_d
);

    localparam int unsigned MAX_AB  = (SETUP_CYC > E_CYC) ? SETUP_CYC : E_CYC;
    localparam int unsigned MAX_CD  = (HOLD_CYC > POST_CYC) ? HOLD_CYC : POST_CYC;
    localparam int unsigned MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned MAX_CYC = (MAX_ABC > TICK_CYC) ? MAX_ABC : TICK_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Phase counters count down from length-1 to 0.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] POST_LD  = CNT_W'(POST_CYC - 1);
    localparam logic [CNT_W-1:0] TICK_LD  = CNT_W'(TICK_CYC - 1);

    localparam logic [1:0] OP_BYTE  = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_NSETUP, S_NE, S_NHOLD,
        S_POST, S_DELAY, S_NEXT, S_DONE
    } state_t;

    state_t                  state_q, state_nxt;
    logic [CNT_W-1:0]        cnt_q, cnt_nxt;
    logic [13:0]             dly_q, dly_nxt;
    logic [3:0]              lo_nib_q, lo_nib_nxt;
    logic                    nib_lo_q, nib_lo_nxt;
    logic [ADDR_WIDTH-1:0]   raddr_nxt;
    logic                    busy_nxt, done_nxt, rs_nxt, e_nxt;
    logic [3:0]              d_nxt;
    logic                    cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dly_q    <= '0;
            lo_nib_q <= '0;
            nib_lo_q <= 1'b0;
            o_raddr  <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_lcd_rs <= 1'b0;
            o_lcd_e  <= 1'b0;
            o_lcd_d  <= '0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            dly_q    <= dly_nxt;
            lo_nib_q <= lo_nib_nxt;
            nib_lo_q <= nib_lo_nxt;
            o_raddr  <= raddr_nxt;
            o_busy   <= busy_nxt;
            o_done   <= done_nxt;
            o_lcd_rs <= rs_nxt;
            o_lcd_e  <= e_nxt;
            o_lcd_d  <= d_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:   if (i_start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (i_rdata[15:14])
                    OP_BYTE:  state_nxt = S_NSETUP;
                    OP_DELAY: state_nxt = (i_rdata[13:0] == 14'd0) ? S_NEXT : S_DELAY;
                    OP_STOP:  state_nxt = S_DONE;
                    default:  state_nxt = S_NEXT;
                endcase
            end
            S_NSETUP: if (cnt_zero) state_nxt = S_NE;
            S_NE:     if (cnt_zero) state_nxt = S_NHOLD;
            S_NHOLD:  if (cnt_zero) state_nxt = nib_lo_q ? S_POST : S_NSETUP;
            S_POST:   if (cnt_zero) state_nxt = S_NEXT;
            S_DELAY:  if (cnt_zero && (dly_q == 14'd1)) state_nxt = S_NEXT;
            S_NEXT:   state_nxt = S_FETCH;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output next values; E/busy/done follow the state being entered.
    always_comb begin
        cnt_nxt    = cnt_q;
        dly_nxt    = dly_q;
        lo_nib_nxt = lo_nib_q;
        nib_lo_nxt = nib_lo_q;
        raddr_nxt  = o_raddr;
        rs_nxt     = o_lcd_rs;
        d_nxt      = o_lcd_d;
        e_nxt      = (state_nxt == S_NE);
        busy_nxt   = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        done_nxt   = (state_nxt == S_DONE);
        case (state_q)
            S_IDLE: if (i_start) raddr_nxt = i_start_addr;
            S_DECODE: begin
                lo_nib_nxt = i_rdata[3:0];
                nib_lo_nxt = 1'b0;
                dly_nxt    = i_rdata[13:0];
                if (i_rdata[15:14] == OP_BYTE) begin
                    cnt_nxt = SETUP_LD;
                    rs_nxt  = i_rdata[8];
                    d_nxt   = i_rdata[7:4];
                end else begin
                    cnt_nxt = TICK_LD;
                end
            end
            S_NSETUP: cnt_nxt = cnt_zero ? E_LD : cnt_q - CNT_W'(1);
            S_NE:     cnt_nxt = cnt_zero ? HOLD_LD : cnt_q - CNT_W'(1);
            S_NHOLD: begin
                if (!cnt_zero) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end else if (!nib_lo_q) begin
                    nib_lo_nxt = 1'b1;
                    d_nxt      = lo_nib_q;
                    cnt_nxt    = SETUP_LD;
                end else begin
                    cnt_nxt = POST_LD;
                end
            end
            S_POST: if (!cnt_zero) cnt_nxt = cnt_q - CNT_W'(1);
            S_DELAY: begin
                if (cnt_zero) begin
                    cnt_nxt = TICK_LD;
                    dly_nxt = dly_q - 14'd1;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            S_NEXT:  raddr_nxt = o_raddr + ADDR_WIDTH'(1);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hd44780_seq.sv
// Directed bench for hd44780_seq with a 1-cycle registered-read RAM model.
module tb_hd44780_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [7:0]  i_start_addr;
    logic [7:0]  o_raddr;
    logic [15:0] i_rdata;
    logic        o_busy, o_done, o_lcd_rs, o_lcd_e;
    logic [3:0]  o_lcd_d;

    logic [15:0] mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    // Per-run observations
    logic [4:0] nib_q [$];
    int         rise_q [$];
    int         wid_q [$];
    logic [7:0] addr_q [$];
    int         done_n, done_cnt;
    logic       busy_first, busy_pre, busy_done;

    hd44780_seq #(
        .ADDR_WIDTH(8), .SETUP_CYC(1), .E_CYC(2), .HOLD_CYC(2),
        .POST_CYC(3), .TICK_CYC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_start_addr(i_start_addr),
        .o_raddr(o_raddr), .i_rdata(i_rdata), .o_busy(o_busy), .o_done(o_done),
        .o_lcd_rs(o_lcd_rs), .o_lcd_e(o_lcd_e), .o_lcd_d(o_lcd_d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) i_rdata <= mem[o_raddr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start at addr, observe every cycle at negedge until 4 cycles past done.
    // Optionally re-pulse i_start with alt address at cycle alt_at.
    task automatic run_seq(input logic [7:0] addr, input logic [7:0] alt, input int alt_at);
        int   n;
        int   w;
        logic prev_e;
        nib_q.delete(); rise_q.delete(); wid_q.delete(); addr_q.delete();
        done_n = 0; done_cnt = 0; busy_pre = 1'b0; busy_done = 1'b1;
        @(negedge clk); i_start = 1'b1; i_start_addr = addr;
        @(negedge clk); i_start = 1'b0;
        n = 1; w = 0; prev_e = 1'b0;
        busy_first = o_busy;
        while (n < 200) begin
            if (n == 1 || o_raddr != addr_q[$]) addr_q.push_back(o_raddr);
            if (o_lcd_e && !prev_e) begin
                nib_q.push_back({o_lcd_rs, o_lcd_d});
                rise_q.push_back(n);
                w = 0;
            end
            if (o_lcd_e) w++;
            if (!o_lcd_e && prev_e) wid_q.push_back(w);
            if (o_done) begin
                done_cnt++;
                if (done_n == 0) begin
                    done_n    = n;
                    busy_done = o_busy;
                end
            end
            if (done_n == 0) busy_pre = o_busy;
            prev_e = o_lcd_e;
            if (done_n != 0 && n >= done_n + 4) break;
            if (n == alt_at) begin
                i_start = 1'b1; i_start_addr = alt;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk); n++;
        end
        i_start = 1'b0;
        chk("done_seen", 32'(done_n != 0), 32'd1);
    endtask

    // Common checks for a single-byte run (byte word followed by stop).
    task automatic chk_byte(input string t, input logic [4:0] hi, input logic [4:0] lo,
                            input logic [7:0] a0, input logic [7:0] a1);
        chk({t, "_done_n"},   done_n, 19);
        chk({t, "_done_cnt"}, done_cnt, 1);
        chk({t, "_nibs"},     nib_q.size(), 2);
        chk({t, "_nib_hi"},   nib_q[0], hi);
        chk({t, "_nib_lo"},   nib_q[1], lo);
        chk({t, "_rise0"},    rise_q[0], 4);
        chk({t, "_rise1"},    rise_q[1], 9);
        chk({t, "_wid0"},     wid_q[0], 2);
        chk({t, "_wid1"},     wid_q[1], 2);
        chk({t, "_naddr"},    addr_q.size(), 2);
        chk({t, "_addr0"},    addr_q[0], a0);
        chk({t, "_addr1"},    addr_q[1], a1);
    endtask

    initial begin
        int   k;
        logic seen;
        rst_n = 1'b0; i_start = 1'b0; i_start_addr = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
        repeat (3) @(negedge clk);
        chk("rst_raddr", o_raddr, 0);
        chk("rst_busy",  o_busy, 0);
        chk("rst_done",  o_done, 0);
        chk("rst_e",     o_lcd_e, 0);
        chk("rst_rs",    o_lcd_rs, 0);
        chk("rst_d",     o_lcd_d, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: data byte 0x28 with RS=1
        mem[0] = 16'h0128; mem[1] = 16'hC000;
        run_seq(8'h00, 8'h00, 0);
        chk_byte("t1", 5'h12, 5'h18, 8'h00, 8'h01);
        chk("t1_busy_first", busy_first, 1);
        chk("t1_busy_pre",   busy_pre, 1);
        chk("t1_busy_done",  busy_done, 0);

        // 2: delay of 5 ticks
        mem[4] = 16'h4005; mem[5] = 16'hC000;
        run_seq(8'h04, 8'h00, 0);
        chk("t2_done_n",   done_n, 16);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_nibs",     nib_q.size(), 0);
        chk("t2_naddr",    addr_q.size(), 2);
        chk("t2_addr0",    addr_q[0], 8'h04);
        chk("t2_addr1",    addr_q[1], 8'h05);

        // 3: zero delay and reserved op are skipped
        mem[8] = 16'h4000; mem[9] = 16'h8123; mem[10] = 16'hC000;
        run_seq(8'h08, 8'h00, 0);
        chk("t3_done_n", done_n, 9);
        chk("t3_nibs",   nib_q.size(), 0);
        chk("t3_naddr",  addr_q.size(), 3);
        chk("t3_addr0",  addr_q[0], 8'h08);
        chk("t3_addr1",  addr_q[1], 8'h09);
        chk("t3_addr2",  addr_q[2], 8'h0A);

        // 4: address wrap 0xFF -> 0x00, command byte 0x33
        mem[8'hFF] = 16'h0033; mem[0] = 16'hC000;
        run_seq(8'hFF, 8'h00, 0);
        chk_byte("t4", 5'h03, 5'h03, 8'hFF, 8'h00);
        chk("t4_raddr_end", o_raddr, 8'h00);

        // 5: reset during the first E pulse
        mem[0] = 16'h0128; mem[1] = 16'hC000;
        @(negedge clk); i_start = 1'b1; i_start_addr = 8'h00;
        @(negedge clk); i_start = 1'b0;
        k = 0;
        while (!o_lcd_e && k < 20) begin
            @(negedge clk); k++;
        end
        chk("t5_reach_ne", o_lcd_e, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_e",    o_lcd_e, 0);
        chk("t5_rst_busy", o_busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | o_lcd_e | o_busy | o_done;
        end
        chk("t5_idle", seen, 0);
        run_seq(8'h00, 8'h00, 0);
        chk_byte("t5r", 5'h12, 5'h18, 8'h00, 8'h01);

        // 6: start while busy is ignored
        run_seq(8'h04, 8'h00, 3);
        chk("t6_done_n",   done_n, 16);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_nibs",     nib_q.size(), 0);
        chk("t6_naddr",    addr_q.size(), 2);
        chk("t6_addr0",    addr_q[0], 8'h04);
        chk("t6_addr1",    addr_q[1], 8'h05);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hd44780_seq.md
Name: hd44780_seq

Overview:
- Reader/player end of the hd44780_ram write path.
- Fetches 16-bit command words from the dual-port RAM read port, starting at a given address.
- Decodes each word as an LCD byte write, a timed delay, or a stop.
- Drives an HD44780 in 4-bit mode (write-only, RW tied low externally) with parameterised setup, E-pulse, hold and post-command timing.

Parameters:
ADDR_WIDTH, 8, RAM address width; must match the RAM instance.
SETUP_CYC, 2, clocks RS/D stable before E rises.
E_CYC, 12, clocks E held high per nibble.
HOLD_CYC, 12, clocks E low after each nibble, RS/D held.
POST_CYC, 2000, clocks idle after the second nibble of a byte.
TICK_CYC, 48, clocks per delay tick (1 us at 48 MHz).

Ports:
clk  in  1  single system clock; the RAM rclk is tied to this clk.
rst_n  in  1  asynchronous active-low reset.
i_start  in  1  start request, sampled only in IDLE.
i_start_addr  in  ADDR_WIDTH  first word address.
o_raddr  out  ADDR_WIDTH  RAM read address.
i_rdata  in  16  RAM dout; valid the clock after o_raddr changes (registered read).
o_busy  out  1  high from the cycle after start is accepted until DONE.
o_done  out  1  one-cycle pulse when a stop word completes.
o_lcd_rs  out  1  LCD register select.
o_lcd_e  out  1  LCD enable.
o_lcd_d  out  4  LCD data nibble (D7..D4).

Behaviour:
- Reset values (asynchronous, all outputs and state):
  - o_raddr=0, o_busy=0, o_done=0, o_lcd_rs=0, o_lcd_e=0, o_lcd_d=0; state IDLE; all counters 0.
- Word format:
  - [15:14]=op.
  - op 00 = byte: RS=[8], byte=[7:0]; [13:9] ignored.
  - op 01 = delay: count=[13:0] ticks.
  - op 11 = stop.
  - op 10 = reserved; treated as no-op and skipped.
- IDLE:
  - On i_start=1: o_raddr<=i_start_addr, o_busy<=1, go to FETCH.
  - i_start while busy is ignored.
- FETCH: one wait cycle for the RAM read latency; go to DECODE.
- DECODE: latch i_rdata into the word register, then branch on op:
  - byte: load the high nibble, go to NSETUP.
  - delay with count=0: go to NEXT.
  - delay with count>0: go to DELAY.
  - stop: go to DONE.
  - reserved: go to NEXT.
- Nibble phases (o_lcd_rs and o_lcd_d held constant across all three):
  - NSETUP: o_lcd_e=0 for SETUP_CYC cycles.
  - NE: o_lcd_e=1 for E_CYC cycles.
  - NHOLD: o_lcd_e=0 for HOLD_CYC cycles.
  - After the high nibble: load the low nibble, repeat from NSETUP.
  - After the low nibble: go to POST.
- POST: POST_CYC cycles with E low, then go to NEXT.
- DELAY: count*TICK_CYC cycles, then go to NEXT. The 14-bit count times TICK_CYC needs no overflow: use a separate tick counter and count counter.
- NEXT: o_raddr<=o_raddr+1, modulo 2^ADDR_WIDTH (0xFF wraps to 0x00); go to FETCH.
- DONE: o_done=1 for one cycle, o_busy<=0, o_lcd_e=0, return to IDLE. o_raddr keeps the stop-word address.
- Total clocks per byte word, excluding FETCH/DECODE/NEXT overhead: 2*(SETUP_CYC+E_CYC+HOLD_CYC)+POST_CYC.
- All phase counters must accept values of at least 1.
- o_lcd_e is only high in NE and is glitch-free (registered).
- Reset mid-operation aborts immediately with E low; no partial nibble completes.
- The RAM may be rewritten while the sequencer runs. Each word is used exactly as read in FETCH/DECODE.
- No RAM write-side ports.

Test Plan (params SETUP_CYC=1, E_CYC=2, HOLD_CYC=2, POST_CYC=3, TICK_CYC=2, RAM model with 1-cycle registered read):
1. RAM[0]=0x0128, RAM[1]=0xC000, start at 0:
   - Required: nibble 0x2 then 0x8 with RS=1, each shows E high for exactly 2 clocks.
   - Required: 5 clocks per nibble, 3 post clocks; o_done pulses once; o_busy falls with done.
2. RAM[4]=0x4005, RAM[5]=0xC000, start at 4:
   - Required: no E activity, 10 clocks in DELAY, then o_done.
   - Required: o_raddr sequence 4, 5.
3. Delay count 0 (0x4000) and reserved 0x8123 before a stop:
   - Required: both skipped with no E pulse or wait; o_raddr advances through all three words.
4. RAM[0xFF]=0x0033, RAM[0x00]=0xC000, start at 0xFF:
   - Required: byte 0x33 with RS=0, address wraps to 0x00, o_done.
5. Assert rst_n=0 during the NE phase of the first nibble:
   - Required: o_lcd_e=0 and o_busy=0 asynchronously; after release, the block is idle.
   - Required: a fresh i_start replays from i_start_addr.
6. Pulse i_start again while busy with a different address:
   - Required: ignored; the sequence completes unchanged and exactly one o_done pulse occurs.
